// File: rtl/sub_module_pipe_if.sv
// Handshake and data bundle for sub_module_pipe: upstream beat in, downstream beat out.
// The master modport drives upstream data and downstream ready; the slave is the pipeline.
interface sub_module_pipe_if #(
  parameter int WIDTH = 4
);
  logic             io_in_valid;
  logic             io_in_ready;
  logic [WIDTH-1:0] io_inp;
  logic             io_mode;
  logic             io_out_valid;
  logic             io_out_ready;
  logic [WIDTH-1:0] io_out;
  logic             io_out_ovf;
  logic [7:0]       io_count;

  modport master (
    output io_in_valid, io_inp, io_mode, io_out_ready,
    input  io_in_ready, io_out_valid, io_out, io_out_ovf, io_count
  );

  modport slave (
    input  io_in_valid, io_inp, io_mode, io_out_ready,
    output io_in_ready, io_out_valid, io_out, io_out_ovf, io_count
  );
endinterface

// File: rtl/sub_module_pipe.sv
// Elastic pipeline of STAGES increment stages; each adds STEP with wrap or saturate
// behaviour chosen per beat, carries a sticky overflow flag, and counts delivered beats.
module sub_module_pipe #(
  parameter int WIDTH  = 4,
  parameter int STAGES = 2,
  parameter int STEP   = 1
) (
  input  logic              clock,
  input  logic              reset,
  sub_module_pipe_if.slave  bus
);

  localparam logic [WIDTH:0] STEP_EXT = (WIDTH+1)'(STEP);

  function automatic logic [WIDTH:0] add_step(input logic [WIDTH-1:0] a);
    return {1'b0, a} + STEP_EXT;
  endfunction

  function automatic logic [WIDTH-1:0] clamp_sum(input logic [WIDTH:0] s, input logic sat);
    logic [WIDTH-1:0] r;
    if (sat && s[WIDTH]) begin
      r = {WIDTH{1'b1}};
    end else begin
      r = s[WIDTH-1:0];
    end
    return r;
  endfunction

  logic [STAGES-1:0]            valid_q, valid_d;
  logic [STAGES-1:0][WIDTH-1:0] data_q,  data_d;
  logic [STAGES-1:0]            mode_q,  mode_d;
  logic [STAGES-1:0]            ovf_q,   ovf_d;
  logic [7:0]                   count_q, count_d;

  logic [STAGES-1:0]            ready_s;
  logic [STAGES-1:0]            src_valid_s;
  logic [STAGES-1:0][WIDTH-1:0] src_data_s;
  logic [STAGES-1:0]            src_mode_s;
  logic [STAGES-1:0]            src_ovf_s;
  logic                         out_fire_s;
  logic                         unused_mode_s;

  // Stage k can accept when any stage from k downstream has a hole, or the sink is ready.
  always_comb begin
    ready_s = {STAGES{1'b0}};
    for (int k = 0; k < STAGES; k++) begin
      logic rdy;
      rdy = bus.io_out_ready;
      for (int j = k; j < STAGES; j++) begin
        rdy = rdy | ~valid_q[j];
      end
      ready_s[k] = rdy;
    end
  end

  // Feed of each stage: the upstream port for stage 0, the previous stage otherwise.
  always_comb begin
    src_valid_s    = valid_q;
    src_data_s     = data_q;
    src_mode_s     = mode_q;
    src_ovf_s      = ovf_q;
    src_valid_s[0] = bus.io_in_valid;
    src_data_s[0]  = bus.io_inp;
    src_mode_s[0]  = bus.io_mode;
    src_ovf_s[0]   = 1'b0;
    for (int k = 1; k < STAGES; k++) begin
      src_valid_s[k] = valid_q[k-1];
      src_data_s[k]  = data_q[k-1];
      src_mode_s[k]  = mode_q[k-1];
      src_ovf_s[k]   = ovf_q[k-1];
    end
  end

  // Next state per stage: load on transfer, empty when drained without refill, else hold.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    mode_d  = mode_q;
    ovf_d   = ovf_q;
    for (int k = 0; k < STAGES; k++) begin
      logic [WIDTH:0] sum;
      sum = add_step(src_data_s[k]);
      if (ready_s[k]) begin
        valid_d[k] = src_valid_s[k];
        if (src_valid_s[k]) begin
          data_d[k] = clamp_sum(sum, src_mode_s[k]);
          mode_d[k] = src_mode_s[k];
          ovf_d[k]  = src_ovf_s[k] | sum[WIDTH];
        end else begin
          data_d[k] = data_q[k];
          mode_d[k] = mode_q[k];
          ovf_d[k]  = ovf_q[k];
        end
      end else begin
        valid_d[k] = valid_q[k];
        data_d[k]  = data_q[k];
        mode_d[k]  = mode_q[k];
        ovf_d[k]   = ovf_q[k];
      end
    end
  end

  assign out_fire_s = valid_q[STAGES-1] & bus.io_out_ready;

  // Delivered-beat counter, wraps naturally at 8 bits.
  always_comb begin
    if (out_fire_s) begin
      count_d = count_q + 8'd1;
    end else begin
      count_d = count_q;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!reset) begin
      valid_q <= {STAGES{1'b0}};
      data_q  <= '{default: {WIDTH{1'b0}}};
      mode_q  <= {STAGES{1'b0}};
      ovf_q   <= {STAGES{1'b0}};
      count_q <= 8'd0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      mode_q  <= mode_d;
      ovf_q   <= ovf_d;
      count_q <= count_d;
    end
  end

  // The last stage's mode has no consumer once the result is final.
  assign unused_mode_s    = mode_q[STAGES-1];

  assign bus.io_in_ready  = ready_s[0];
  assign bus.io_out_valid = valid_q[STAGES-1];
  assign bus.io_out       = data_q[STAGES-1];
  assign bus.io_out_ovf   = ovf_q[STAGES-1];
  assign bus.io_count     = count_q;

endmodule

// File: tb/tb_sub_module_pipe.sv
// Scoreboard bench for sub_module_pipe: accepted beats are modelled arithmetically and
// queued; a negedge monitor pops and compares every delivered beat and the beat counter.
module tb_sub_module_pipe;
  localparam int WIDTH  = 4;
  localparam int STAGES = 2;
  localparam int STEP   = 1;
  localparam int MAXV   = 1 << WIDTH;

  logic clock;
  logic reset;
  int   checks;
  int   errors;
  int   delivered;
  logic [7:0]     exp_count;
  logic [WIDTH:0] exp_q[$];

  sub_module_pipe_if #(.WIDTH(WIDTH)) bus ();

  sub_module_pipe #(.WIDTH(WIDTH), .STAGES(STAGES), .STEP(STEP)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Whole-pipeline result: STAGES*STEP added at once, overflow iff the true sum exceeds the range.
  function automatic logic [WIDTH:0] model(input int inp, input bit mode);
    int t;
    int r;
    bit o;
    t = inp + STAGES * STEP;
    o = (t >= MAXV);
    if (mode) r = o ? (MAXV - 1) : t;
    else      r = t % MAXV;
    return {o, r[WIDTH-1:0]};
  endfunction

  // Monitor: checks counter, pops expected results on delivery, pushes on acceptance.
  always @(negedge clock) begin
    if (!reset) begin
      exp_q.delete();
      exp_count = 8'd0;
    end else begin
      chk("count", int'(bus.io_count), int'(exp_count));
      if (bus.io_out_valid && bus.io_out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_beat: got data %0d with no beat outstanding", bus.io_out);
        end else begin
          logic [WIDTH:0] e;
          e = exp_q.pop_front();
          chk("out_data", int'(bus.io_out), int'(e[WIDTH-1:0]));
          chk("out_ovf", int'(bus.io_out_ovf), int'(e[WIDTH]));
        end
        exp_count = exp_count + 8'd1;
        delivered++;
      end
      if (bus.io_in_valid && bus.io_in_ready) begin
        exp_q.push_back(model(int'(bus.io_inp), bus.io_mode));
      end
    end
  end

  task automatic send(input int v, input bit m);
    bit acc;
    acc = 1'b0;
    @(posedge clock); #1;
    bus.io_in_valid = 1'b1;
    bus.io_inp      = WIDTH'(v);
    bus.io_mode     = m;
    for (int i = 0; i < 50 && !acc; i++) begin
      @(negedge clock);
      acc = bus.io_in_ready;
      @(posedge clock); #1;
    end
    bus.io_in_valid = 1'b0;
    checks++;
    if (!acc) begin
      errors++;
      $display("FAIL send_timeout: beat %0d got accepted=%0d, expected 1", v, acc);
    end
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    delivered = 0;
    exp_count = 8'd0;
    reset            = 1'b0;
    bus.io_in_valid  = 1'b0;
    bus.io_inp       = '0;
    bus.io_mode      = 1'b0;
    bus.io_out_ready = 1'b1;
    repeat (3) @(posedge clock);
    #1 reset = 1'b1;

    // Reset state
    @(negedge clock);
    chk("rst_out_valid", int'(bus.io_out_valid), 0);
    chk("rst_out", int'(bus.io_out), 0);
    chk("rst_ovf", int'(bus.io_out_ovf), 0);
    chk("rst_count", int'(bus.io_count), 0);
    chk("rst_in_ready", int'(bus.io_in_ready), 1);

    // Latency: 3 -> 5 after exactly STAGES edges
    @(posedge clock); #1;
    bus.io_in_valid = 1'b1; bus.io_inp = 4'd3; bus.io_mode = 1'b0;
    @(negedge clock);
    chk("lat_in_ready", int'(bus.io_in_ready), 1);
    @(posedge clock); #1 bus.io_in_valid = 1'b0;
    @(negedge clock);
    chk("lat_valid_early", int'(bus.io_out_valid), 0);
    @(posedge clock);
    @(negedge clock);
    chk("lat_valid", int'(bus.io_out_valid), 1);
    chk("lat_out", int'(bus.io_out), 5);
    chk("lat_ovf", int'(bus.io_out_ovf), 0);
    @(posedge clock);
    @(negedge clock);
    chk("lat_count", int'(bus.io_count), 1);

    // Wrap and saturate boundaries, checked by the scoreboard
    send(15, 1'b0);
    send(14, 1'b1);
    send(13, 1'b1);
    repeat (4) @(posedge clock);

    // Back-pressure: two beats fill the pipe, the third waits
    #1 bus.io_out_ready = 1'b0;
    bus.io_in_valid = 1'b1; bus.io_inp = 4'd2; bus.io_mode = 1'b0;
    @(posedge clock); #1 bus.io_inp = 4'd4;
    @(posedge clock); #1 bus.io_inp = 4'd6;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      chk("bp_in_ready", int'(bus.io_in_ready), 0);
      chk("bp_hold_out", int'(bus.io_out), 4);
      @(posedge clock);
    end
    #1 bus.io_out_ready = 1'b1;
    @(negedge clock);
    chk("bp_rel_out0", int'(bus.io_out), 4);
    chk("bp_rel_ready", int'(bus.io_in_ready), 1);
    @(posedge clock); #1 bus.io_in_valid = 1'b0;
    @(negedge clock);
    chk("bp_rel_valid1", int'(bus.io_out_valid), 1);
    chk("bp_rel_out1", int'(bus.io_out), 6);
    @(posedge clock);
    @(negedge clock);
    chk("bp_rel_valid2", int'(bus.io_out_valid), 1);
    chk("bp_rel_out2", int'(bus.io_out), 8);
    repeat (4) @(posedge clock);

    // Reset mid-flight discards in-flight beats
    #1 bus.io_in_valid = 1'b1; bus.io_inp = 4'd2;
    @(posedge clock); #1 bus.io_inp = 4'd5;
    @(posedge clock); #1 bus.io_in_valid = 1'b0; reset = 1'b0;
    @(posedge clock); #1 reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      chk("mid_out_valid", int'(bus.io_out_valid), 0);
      chk("mid_count", int'(bus.io_count), 0);
      chk("mid_in_ready", int'(bus.io_in_ready), 1);
      @(posedge clock);
    end

    // Randomised traffic with mixed modes; long enough to wrap the counter
    delivered = 0;
    for (int c = 0; c < 800; c++) begin
      #1;
      bus.io_in_valid  = ($urandom_range(0, 9) < 7);
      bus.io_inp       = WIDTH'($urandom_range(0, MAXV - 1));
      bus.io_mode      = 1'($urandom_range(0, 1));
      bus.io_out_ready = ($urandom_range(0, 9) < 7);
      @(posedge clock);
    end
    #1;
    bus.io_in_valid  = 1'b0;
    bus.io_out_ready = 1'b1;
    repeat (6) @(posedge clock);
    @(negedge clock);
    chk("drained", exp_q.size(), 0);
    checks++;
    if (delivered < 256) begin
      errors++;
      $display("FAIL wrap_coverage: got %0d beats delivered, expected at least 256", delivered);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end
endmodule

// File: doc/sub_module_pipe.md
SUB_MODULE_PIPE -- requirements
Module: sub_module_pipe

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, meaning data width in bits (WIDTH >= 1).
REQ-002 The block SHALL have parameter STAGES, default 2, meaning the number of increment stages (STAGES >= 1).
REQ-003 The block SHALL have parameter STEP, default 1, meaning the constant added per stage (1 <= STEP <= 2^WIDTH-1).
REQ-004 The block SHALL have port clock, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit: reset, synchronous and active-low (0 = reset asserted).
REQ-006 The block SHALL have port io_in_valid, input, 1 bit: the upstream beat is present.
REQ-007 The block SHALL have port io_in_ready, output, 1 bit: stage 0 can accept a beat this cycle.
REQ-008 The block SHALL have port io_inp, input, WIDTH bits: the input operand.
REQ-009 The block SHALL have port io_mode, input, 1 bit: 0 = wrap arithmetic, 1 = saturate arithmetic; sampled with the beat.
REQ-010 The block SHALL have port io_out_valid, output, 1 bit: the last stage holds a beat.
REQ-011 The block SHALL have port io_out_ready, input, 1 bit: downstream accepts the beat.
REQ-012 The block SHALL have port io_out, output, WIDTH bits: the result operand.
REQ-013 The block SHALL have port io_out_ovf, output, 1 bit: sticky overflow seen at any stage for this beat.
REQ-014 The block SHALL have port io_count, output, 8 bits: the number of beats delivered, wrapping.

Function
REQ-015 Each stage k SHALL hold registers valid_k, data_k (WIDTH), mode_k, ovf_k.
REQ-016 A beat SHALL transfer at an interface when valid and ready are both 1 in the same cycle.
REQ-017 ready_k SHALL equal (!valid_k || ready_{k+1}); ready_STAGES = io_out_ready; io_in_ready = ready_0 (combinational, no register).
REQ-018 On a transfer into stage k, the sum s = data_{k-1} + STEP SHALL be computed in WIDTH+1 bits (stage 0 uses io_inp, with ovf_in = 0).
REQ-019 Wrap mode: data_k SHALL take s[WIDTH-1:0]; ovf_k SHALL take ovf_{k-1} | s[WIDTH].
REQ-020 Saturate mode: data_k SHALL take all-ones when s[WIDTH] = 1, else s[WIDTH-1:0]; ovf_k SHALL take ovf_{k-1} | s[WIDTH].
REQ-021 mode_k SHALL be copied from the previous stage (or from io_mode at stage 0), so a beat keeps its mode across stages.
REQ-022 When stage k is valid and ready_{k+1} = 0, stage k SHALL hold all its registers unchanged.
REQ-023 When stage k empties without a new beat arriving, valid_k SHALL go to 0.
REQ-024 Simultaneous drain and fill of stage k in one cycle SHALL replace its contents with no bubble.
REQ-025 Latency with no stall SHALL be exactly STAGES cycles from input transfer to io_out_valid = 1.
REQ-026 Sustained throughput SHALL be one beat per cycle while io_out_ready = 1.
REQ-027 Beats SHALL leave in acceptance order; none is dropped or duplicated while reset is deasserted.
REQ-028 io_out, io_out_ovf, and io_out_valid SHALL be driven directly from the last-stage registers.
REQ-029 io_count SHALL increment by 1 on each output transfer and wrap from 255 to 0.
REQ-030 Input data SHALL be ignored when io_in_valid = 0; outputs SHALL not change because of io_out_ready while io_out_valid = 0.

Reset
REQ-031 While reset = 0 at a rising clock edge, every valid_k, data_k, mode_k, and ovf_k SHALL clear to 0, and io_count SHALL clear to 0.
REQ-032 After reset: io_out_valid = 0, io_out = 0, io_out_ovf = 0, io_count = 0, and io_in_ready = 1.
REQ-033 Reset asserted mid-operation SHALL discard all in-flight beats without delivering them.
REQ-034 No beat SHALL be accepted in a cycle where reset = 0.

Verification (WIDTH=4, STAGES=2, STEP=1)
REQ-035 Latency: send io_inp=3, mode=0, out_ready=1 -> exactly 2 cycles later io_out_valid=1, io_out=5, ovf=0, io_count becomes 1.
REQ-036 Wrap: send io_inp=15, mode=0 -> io_out=1, io_out_ovf=1.
REQ-037 Saturate: send io_inp=14, mode=1 -> io_out=15, io_out_ovf=1; send io_inp=13, mode=1 -> io_out=15, ovf=0.
REQ-038 Back-pressure: hold out_ready=0 and offer 2, 4, 6 -> 2 beats accepted and io_in_ready=0 while the third waits; release -> outputs 4, 6, 8 in order, one per cycle, no bubble.
REQ-039 Reset mid-flight: accept 2 beats, assert reset=0 for 1 cycle -> no output beat appears; io_out_valid=0, io_count=0, io_in_ready=1.
REQ-040 Counter wrap: deliver 256 beats -> io_count returns to 0; mixed modes per beat are each honoured.
